serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures a, b and bin on start, resolves one bit per
// cycle LSB-first, then presents diff/borrow together with a one-cycle done strobe.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_bit;
  logic             br_next;

  function automatic logic diff_bit(input logic ai, input logic bi, input logic br);
    return ai ^ bi ^ br;
  endfunction

  function automatic logic borrow_bit(input logic ai, input logic bi, input logic br);
    return (~ai & bi) | (~(ai ^ bi) & br);
  endfunction

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_bit    = diff_bit(a_q[0], b_q[0], br_q);
    br_next  = borrow_bit(a_q[0], b_q[0], br_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Operands shift right; result bits enter acc from the top so the
        // first (LSB) bit lands in bit 0 after WIDTH shifts.
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        acc_d = {d_bit, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d   = {d_bit, acc_q[WIDTH-1:1]};
          borrow_d = br_next;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): hand-computed results,
// latency, busy span, start masking, async reset abort and back-to-back runs.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       bin = 1'b0;
  logic [3:0] diff;
  logic       borrow;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails  = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .borrow(borrow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Present operands with start for exactly one rising edge.
  task automatic launch(input logic [3:0] av, input logic [3:0] bv, input logic binv);
    @(negedge clk);
    a = av; b = bv; bin = binv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the number of negedges after the accepting edge until done (-1 on timeout).
  task automatic wait_done(output int lat, output logic [3:0] dv, output logic bv);
    lat = -1; dv = 'x; bv = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; dv = diff; bv = borrow;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, borrow, diff} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b borrow=%b diff=%h, want all 0", busy, done, borrow, diff);
    end
    start = 1'b1; a = 4'h7; b = 4'h1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ignores_start: busy=%b done=%b, want 0 0", busy, done);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_borrow_wrap;
    int lat; logic [3:0] dv; logic bv;
    launch(4'b0001, 4'b0001, 1'b1);
    wait_done(lat, dv, bv);
    checks++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL wrap_latency: got %0d, want 4", lat);
    end
    checks++;
    if (dv !== 4'hF || bv !== 1'b1) begin
      fails++;
      $display("FAIL wrap_result: diff=%h borrow=%b, want F 1", dv, bv);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wrap_done_one_cycle: done=%b busy=%b, want 0 0", done, busy);
    end
    checks++;
    if (diff !== 4'hF || borrow !== 1'b1) begin
      fails++;
      $display("FAIL wrap_hold: diff=%h borrow=%b, want F 1", diff, borrow);
    end
  endtask

  task automatic test_basic;
    int busy_cnt = 0;
    int lat = -1;
    logic [3:0] dv = 'x;
    logic bv = 1'bx;
    launch(4'd9, 4'd3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) a = 4'd0;
      if (i == 1) begin b = 4'hF; bin = 1'b1; end
      if (busy) busy_cnt++;
      if (done) begin lat = i; dv = diff; bv = borrow; end
      if (!busy) break;
    end
    checks++;
    if (busy_cnt !== 5) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d, want 5", busy_cnt);
    end
    checks++;
    if (lat !== 4 || dv !== 4'd6 || bv !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: lat=%0d diff=%h borrow=%b, want 4 6 0", lat, dv, bv);
    end
  endtask

  task automatic test_extremes;
    int lat; logic [3:0] dv; logic bv;
    launch(4'h0, 4'hF, 1'b0);
    wait_done(lat, dv, bv);
    checks++;
    if (lat !== 4 || dv !== 4'h1 || bv !== 1'b1) begin
      fails++;
      $display("FAIL zero_minus_f: lat=%0d diff=%h borrow=%b, want 4 1 1", lat, dv, bv);
    end
    launch(4'hF, 4'hF, 1'b0);
    wait_done(lat, dv, bv);
    checks++;
    if (lat !== 4 || dv !== 4'h0 || bv !== 1'b0) begin
      fails++;
      $display("FAIL f_minus_f: lat=%0d diff=%h borrow=%b, want 4 0 0", lat, dv, bv);
    end
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    int lat = -1;
    logic [3:0] dv = 'x;
    logic bv = 1'bx;
    launch(4'd5, 4'd2, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 1) begin start = 1'b1; a = 4'd0; b = 4'd7; bin = 1'b1; end
      if (i == 3) start = 1'b0;
      if (done) begin pulses++; lat = i; dv = diff; bv = borrow; end
    end
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL ignore_pulse_count: got %0d, want 1", pulses);
    end
    checks++;
    if (lat !== 4 || dv !== 4'd3 || bv !== 1'b0) begin
      fails++;
      $display("FAIL ignore_result: lat=%0d diff=%h borrow=%b, want 4 3 0", lat, dv, bv);
    end
  endtask

  task automatic test_reset_abort;
    int pulses = 0;
    int lat; logic [3:0] dv; logic bv;
    launch(4'd9, 4'd3, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy_before: busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, borrow, diff} !== 7'b0) begin
      fails++;
      $display("FAIL abort_async_clear: busy=%b done=%b borrow=%b diff=%h, want all 0", busy, done, borrow, diff);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL abort_no_done: active cycles=%0d, want 0", pulses);
    end
    launch(4'd8, 4'd8, 1'b1);
    wait_done(lat, dv, bv);
    checks++;
    if (lat !== 4 || dv !== 4'hF || bv !== 1'b1) begin
      fails++;
      $display("FAIL after_abort: lat=%0d diff=%h borrow=%b, want 4 F 1", lat, dv, bv);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int last = -1;
    int settle = 0;
    @(negedge clk);
    a = 4'd12; b = 4'd4; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        checks++;
        if (diff !== 4'd8 || borrow !== 1'b0) begin
          fails++;
          $display("FAIL b2b_result: diff=%h borrow=%b, want 8 0", diff, borrow);
        end
        if (last >= 0) begin
          checks++;
          if (i - last !== 6) begin
            fails++;
            $display("FAIL b2b_period: got %0d, want 6", i - last);
          end
        end else begin
          checks++;
          if (i !== 4) begin
            fails++;
            $display("FAIL b2b_first_latency: got %0d, want 4", i);
          end
        end
        last = i;
      end
    end
    checks++;
    if (pulses !== 5) begin
      fails++;
      $display("FAIL b2b_pulse_count: got %0d, want 5", pulses);
    end
    start = 1'b0;
    while (busy && settle < 20) begin
      @(negedge clk);
      settle++;
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_settle: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_borrow_wrap();
    test_basic();
    test_extremes();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
